// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Execute-stage front end feeding the combinational shifter. Decoded shift
//   ops arrive over a valid/ready handshake, are decoded into operand, shift
//   amount and direction/type controls, and are presented from a registered
//   main entry. A second (skid) entry absorbs one op while the main entry is
//   stalled, so in_ready depends on registered state only.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake
//   in_func         : 000 shll, 001 shrl, 010 shra, 011 shllv, 100 shrlv,
//                     101 shrav, 110/111 illegal
//   in_rs, in_rt    : operand, variable shift amount source
//   in_imm_shamt    : immediate shift amount
//   in_tag          : instruction tag
//   flush           : drop everything held plus the same-cycle input
//   sh_in, sh_shamt, sh_left, sh_arith : registered shifter controls
//   out_valid/ready, out_tag           : downstream handshake and tag
//   err_illegal     : one-cycle pulse after an illegal op is consumed
//   illegal_cnt     : saturating count of illegal ops
module shift_issue_stage #(
  parameter int TAG_W          = 4,
  parameter int MASK_VAR_SHAMT = 0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_func,
  input  logic [31:0]          in_rs,
  input  logic [31:0]          in_rt,
  input  logic [4:0]           in_imm_shamt,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 flush,
  output logic [31:0]          sh_in,
  output logic [31:0]          sh_shamt,
  output logic                 sh_left,
  output logic                 sh_arith,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 err_illegal,
  output logic [ERR_CNT_W-1:0] illegal_cnt
);

  // Variable shift amount source: either the full register or its low 5 bits.
  logic [31:0] var_shamt;
  generate
    if (MASK_VAR_SHAMT != 0) begin : g_mask_shamt
      assign var_shamt = {27'b0, in_rt[4:0]};
    end else begin : g_full_shamt
      assign var_shamt = in_rt;
    end
  endgenerate

  // Decode of the incoming op.
  logic        legal;
  logic        dec_left;
  logic        dec_arith;
  logic [31:0] dec_shamt;

  always_comb begin
    legal     = 1'b1;
    dec_left  = 1'b0;
    dec_arith = 1'b0;
    dec_shamt = {27'b0, in_imm_shamt};
    case (in_func)
      3'b000: dec_left = 1'b1;
      3'b001: begin end
      3'b010: dec_arith = 1'b1;
      3'b011: begin dec_left = 1'b1;  dec_shamt = var_shamt; end
      3'b100: dec_shamt = var_shamt;
      3'b101: begin dec_arith = 1'b1; dec_shamt = var_shamt; end
      default: legal = 1'b0;
    endcase
  end

  // Main entry (drives the outputs) and skid entry.
  logic              m_valid_reg, s_valid_reg;
  logic [31:0]       m_in_reg, s_in_reg;
  logic [31:0]       m_shamt_reg, s_shamt_reg;
  logic              m_left_reg, s_left_reg;
  logic              m_arith_reg, s_arith_reg;
  logic [TAG_W-1:0]  m_tag_reg, s_tag_reg;
  logic              err_reg;
  logic [ERR_CNT_W-1:0] cnt_reg;

  logic accept, fire, take_legal, take_illegal;

  assign in_ready     = !s_valid_reg;
  assign accept       = in_valid && in_ready;
  assign fire         = m_valid_reg && out_ready;
  assign take_legal   = accept && legal;
  assign take_illegal = accept && !legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      m_in_reg    <= '0;
      m_shamt_reg <= '0;
      m_left_reg  <= 1'b0;
      m_arith_reg <= 1'b0;
      m_tag_reg   <= '0;
      s_in_reg    <= '0;
      s_shamt_reg <= '0;
      s_left_reg  <= 1'b0;
      s_arith_reg <= 1'b0;
      s_tag_reg   <= '0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      // Illegal ops are consumed even in a flush cycle and still counted.
      err_reg <= take_illegal;
      if (take_illegal && (cnt_reg != {ERR_CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;

      if (flush) begin
        // Payload registers keep their last values; only validity is cleared.
        m_valid_reg <= 1'b0;
        s_valid_reg <= 1'b0;
      end else if (!m_valid_reg || fire) begin
        if (s_valid_reg) begin
          // in_ready is low here, so no new op competes with the skid entry.
          m_valid_reg <= 1'b1;
          m_in_reg    <= s_in_reg;
          m_shamt_reg <= s_shamt_reg;
          m_left_reg  <= s_left_reg;
          m_arith_reg <= s_arith_reg;
          m_tag_reg   <= s_tag_reg;
          s_valid_reg <= 1'b0;
        end else if (take_legal) begin
          m_valid_reg <= 1'b1;
          m_in_reg    <= in_rs;
          m_shamt_reg <= dec_shamt;
          m_left_reg  <= dec_left;
          m_arith_reg <= dec_arith;
          m_tag_reg   <= in_tag;
        end else begin
          m_valid_reg <= 1'b0;
        end
      end else if (take_legal) begin
        s_valid_reg <= 1'b1;
        s_in_reg    <= in_rs;
        s_shamt_reg <= dec_shamt;
        s_left_reg  <= dec_left;
        s_arith_reg <= dec_arith;
        s_tag_reg   <= in_tag;
      end
    end
  end

  assign out_valid   = m_valid_reg;
  assign sh_in       = m_in_reg;
  assign sh_shamt    = m_shamt_reg;
  assign sh_left     = m_left_reg;
  assign sh_arith    = m_arith_reg;
  assign out_tag     = m_tag_reg;
  assign err_illegal = err_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_func = 3'd0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_imm_shamt = '0;
  logic [3:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, sh_left, sh_arith, err_illegal;
  logic [31:0] sh_in, sh_shamt;
  logic [3:0]  out_tag;
  logic [7:0]  illegal_cnt;

  // Second instance with the variable shift amount masked to 5 bits.
  logic        m_in_ready, m_out_valid, m_sh_left, m_sh_arith, m_err_illegal;
  logic [31:0] m_sh_in, m_sh_shamt;
  logic [3:0]  m_out_tag;
  logic [7:0]  m_illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_issue_stage #(.TAG_W(4), .MASK_VAR_SHAMT(0), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_shamt(in_imm_shamt), .in_tag(in_tag), .flush(flush),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_left(sh_left),
    .sh_arith(sh_arith), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
  );

  shift_issue_stage #(.TAG_W(4), .MASK_VAR_SHAMT(1), .ERR_CNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_shamt(in_imm_shamt), .in_tag(in_tag), .flush(flush),
    .sh_in(m_sh_in), .sh_shamt(m_sh_shamt), .sh_left(m_sh_left),
    .sh_arith(m_sh_arith), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_tag(m_out_tag), .err_illegal(m_err_illegal),
    .illegal_cnt(m_illegal_cnt)
  );

  typedef struct {
    logic [31:0] in_v;
    logic [31:0] shamt;
    logic        left;
    logic        arith;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] imm,
                                 input logic [3:0] tag);
    exp_t e;
    e.in_v  = rs;
    e.shamt = (f >= 3'd3) ? rt : {27'b0, imm};
    e.left  = (f == 3'd0) || (f == 3'd3);
    e.arith = (f == 3'd2) || (f == 3'd5);
    e.tag   = tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] imm,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_func = f;
    in_rs = rs;
    in_rt = rt;
    in_imm_shamt = imm;
    in_tag = tag;
  endtask

  // Scoreboard: push on a legal accepted op, pop and compare on a fire.
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got tag %h expected no output", out_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          checks++;
          if (sh_in !== e.in_v || sh_shamt !== e.shamt || sh_left !== e.left ||
              sh_arith !== e.arith || out_tag !== e.tag) begin
            errors++;
            $display("FAIL sb_out: got in=%h shamt=%h l=%b a=%b tag=%h expected in=%h shamt=%h l=%b a=%b tag=%h",
                     sh_in, sh_shamt, sh_left, sh_arith, out_tag,
                     e.in_v, e.shamt, e.left, e.arith, e.tag);
          end else begin
            $display("ok   sb_out tag=%h", out_tag);
          end
        end
      end
      if (in_valid && in_ready && in_func < 3'd6)
        q.push_back(model(in_func, in_rs, in_rt, in_imm_shamt, in_tag));
    end
  end

  typedef struct {
    logic [2:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  imm;
    logic [3:0]  tag;
    logic [31:0] e_shamt;
    logic        e_left;
    logic        e_arith;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit accepted;

    tbl[0] = '{3'd2, 32'hF000_0000, 32'hDEAD_BEEF, 5'd4,  4'h1, 32'd4,        1'b0, 1'b1};
    tbl[1] = '{3'd0, 32'h0000_0001, 32'hDEAD_BEEF, 5'd31, 4'h2, 32'd31,       1'b1, 1'b0};
    tbl[2] = '{3'd1, 32'h8000_0000, 32'hDEAD_BEEF, 5'd0,  4'h3, 32'd0,        1'b0, 1'b0};
    tbl[3] = '{3'd3, 32'h1234_5678, 32'h0000_0025, 5'd7,  4'h4, 32'h25,       1'b1, 1'b0};
    tbl[4] = '{3'd4, 32'hCAFE_F00D, 32'hFFFF_FFFF, 5'd7,  4'h5, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 32'h8765_4321, 32'h0000_0020, 5'd7,  4'h6, 32'd32,       1'b0, 1'b1};

    // Reset held two cycles with a valid op on the input.
    drive(3'd0, 32'hAAAA_AAAA, 32'h0, 5'd3, 4'hF);
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sh_in", sh_in, 0);
    chk("rst_sh_shamt", sh_shamt, 0);
    chk("rst_sh_left", sh_left, 0);
    chk("rst_sh_arith", sh_arith, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle_out_valid", out_valid, 0);

    // Table: back-to-back ops with out_ready high, 1-cycle latency each.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].func, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].tag);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      step();
      chk($sformatf("tbl%0d_out_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_sh_in", i), sh_in, tbl[i].rs);
      chk($sformatf("tbl%0d_sh_shamt", i), sh_shamt, tbl[i].e_shamt);
      chk($sformatf("tbl%0d_sh_left", i), sh_left, tbl[i].e_left);
      chk($sformatf("tbl%0d_sh_arith", i), sh_arith, tbl[i].e_arith);
      chk($sformatf("tbl%0d_out_tag", i), out_tag, tbl[i].tag);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_drained", out_valid, 0);

    // Variable shift amount masking on both instances.
    drive(3'd3, 32'h0000_00FF, 32'h0000_0025, 5'd0, 4'h7);
    step();
    in_valid = 1'b0;
    chk("mask0_shamt", sh_shamt, 32'h25);
    chk("mask1_shamt", m_sh_shamt, 32'h5);
    step();

    // Backpressure: three shllv ops against a stalled consumer.
    out_ready = 1'b0;
    drive(3'd3, 32'h0000_0101, 32'd1, 5'd0, 4'h1);
    step();
    drive(3'd3, 32'h0000_0202, 32'd2, 5'd0, 4'h2);
    chk("bp_ready2", in_ready, 1);
    step();
    drive(3'd3, 32'h0000_0303, 32'd3, 5'd0, 4'h3);
    chk("bp_ready3", in_ready, 0);
    step();
    step();
    chk("bp_hold_tag", out_tag, 1);
    chk("bp_hold_sh_in", sh_in, 32'h0000_0101);
    chk("bp_hold_shamt", sh_shamt, 32'd1);
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("bp_tag3_accepted", {31'b0, accepted}, 1);
    for (int i = 0; i < 4; i++) step();
    chk("bp_queue_empty", q.size(), 0);

    // Single illegal op.
    drive(3'd7, 32'h1, 32'h1, 5'd1, 4'h8);
    step();
    in_valid = 1'b0;
    chk("ill_err_pulse", err_illegal, 1);
    chk("ill_no_out", out_valid, 0);
    chk("ill_cnt1", illegal_cnt, 1);
    step();
    chk("ill_err_clear", err_illegal, 0);
    chk("ill_cnt_hold", illegal_cnt, 1);

    // Flush with both entries full.
    out_ready = 1'b0;
    drive(3'd0, 32'h0000_1111, 32'd0, 5'd1, 4'hA);
    step();
    drive(3'd0, 32'h0000_1112, 32'd0, 5'd2, 4'hB);
    step();
    in_valid = 1'b0;
    chk("fl_full_valid", out_valid, 1);
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1;
    step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_sh_in_kept", sh_in, 32'h0000_1111);
    // Flush drops the same-cycle legal input.
    drive(3'd1, 32'h0000_2222, 32'd0, 5'd3, 4'h9);
    step();
    chk("fl_drop_valid", out_valid, 0);
    chk("fl_drop_sh_in", sh_in, 32'h0000_1111);
    // Illegal op in a flush cycle still counts.
    drive(3'd6, 32'h0, 32'h0, 5'd0, 4'h0);
    step();
    chk("fl_ill_err", err_illegal, 1);
    chk("fl_ill_cnt", illegal_cnt, 2);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(3'd2, 32'h0000_3333, 32'd0, 5'd5, 4'h5);
    step();
    in_valid = 1'b0;
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_tag", out_tag, 5);
    chk("fl_after_sh_in", sh_in, 32'h0000_3333);
    step();

    // Reset with both entries full.
    out_ready = 1'b0;
    drive(3'd4, 32'h0000_4444, 32'd9, 5'd0, 4'hC);
    step();
    drive(3'd4, 32'h0000_5555, 32'd9, 5'd0, 4'hD);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_sh_in", sh_in, 0);
    chk("mr_cnt", illegal_cnt, 0);
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(3'd5, 32'h8000_0001, 32'd3, 5'd0, 4'hE);
    step();
    in_valid = 1'b0;
    chk("mr_after_valid", out_valid, 1);
    chk("mr_after_tag", out_tag, 4'hE);
    step();

    // Saturation of the illegal counter.
    drive(3'd7, 32'h0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < 254; i++) step();
    chk("sat_cnt254", illegal_cnt, 254);
    step();
    chk("sat_cnt255", illegal_cnt, 255);
    for (int i = 0; i < 45; i++) step();
    in_valid = 1'b0;
    chk("sat_cnt_hold", illegal_cnt, 255);
    chk("sat_no_out", out_valid, 0);
    step();
    chk("sat_err_clear", err_illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-stage front end that sits directly upstream of the combinational shifter.
- Accepts decoded shift instructions from the register-read stage over a valid/ready handshake and decodes the 3-bit shift function.
- Forms the operand and shift amount, then presents registered, stable controls (in, shamt, left_shift, arithmetic_shift) to the shifter.
- A 2-entry skid buffer breaks the ready path; illegal function codes are consumed, reported and dropped.

Parameters:
- TAG_W, 4, width of the instruction tag carried alongside each op.
- MASK_VAR_SHAMT, 0, 1 = variable shamt uses rt_data[4:0] only; 0 = full 32-bit rt_data is passed through.
- ERR_CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op this cycle.
- in_func  input  3  000 shll, 001 shrl, 010 shra, 011 shllv, 100 shrlv, 101 shrav, 110/111 illegal.
- in_rs  input  32  value to be shifted.
- in_rt  input  32  variable shift amount source.
- in_imm_shamt  input  5  immediate shift amount.
- in_tag  input  TAG_W  instruction tag.
- flush  input  1  synchronous pipeline flush.
- sh_in  output  32  operand to shifter.
- sh_shamt  output  32  shift amount to shifter.
- sh_left  output  1  left_shift to shifter.
- sh_arith  output  1  arithmetic_shift to shifter.
- out_valid  output  1  sh_* and out_tag hold a valid op.
- out_ready  input  1  downstream (shifter result consumer) takes the op.
- out_tag  output  TAG_W  tag of the op presented.
- err_illegal  output  1  one-cycle pulse, illegal func consumed.
- illegal_cnt  output  ERR_CNT_W  saturating count of illegal ops.

Behaviour:
- Reset (rst=1 at clock edge): both entries invalid.
  - sh_in=0, sh_shamt=0, sh_left=0, sh_arith=0, out_tag=0, out_valid=0.
  - err_illegal=0, illegal_cnt=0; in_ready=1 in the cycle after reset.
  - rst overrides every other input, including mid-operation: held ops are discarded, never presented.
- Decode, applied on capture (all registered):
  - Immediate forms (000/001/010): sh_shamt = {27'b0, in_imm_shamt}.
  - Variable forms (011/100/101): sh_shamt = in_rt, or {27'b0, in_rt[4:0]} when MASK_VAR_SHAMT=1.
  - sh_left = 1 for 000/011 only. sh_arith = 1 for 010/101 only.
  - sh_left and sh_arith are never both 1. sh_in = in_rs.
- Storage: main entry M (drives the outputs) and skid entry S.
  - in_ready = !S.valid, registered state only; no combinational path from out_ready.
  - accept = in_valid & in_ready; legal = func not in {110,111}. fire = out_valid & out_ready.
- Per-cycle update when flush=0:
  - If M empty or fire:
    - S valid: M <= S, S <= empty. No accept is possible, since in_ready=0.
    - S empty: M <= decoded input if accept&legal, else M becomes empty.
  - Else (M full, stalled): if accept&legal then S <= decoded input.
  - Order is strictly preserved; latency from accept to out_valid is 1 cycle when M is empty or firing.
  - Throughput is 1 op/cycle with out_ready held high.
  - sh_* and out_tag hold stable while out_valid=1 and out_ready=0.
- Illegal ops: if accept & !legal, the op is consumed (handshake completes) and not stored.
  - err_illegal=1 on the next cycle for exactly one cycle.
  - illegal_cnt increments, saturating at 2^ERR_CNT_W-1.
- flush=1: M and S become invalid next cycle; the same-cycle input is dropped; out_valid=0 next cycle.
  - sh_* keep their last values; err_illegal and illegal_cnt are unaffected, except that an illegal op accepted in the flush cycle still counts.
- shamt >= 32 is legal and forwarded unchanged; result semantics belong to the shifter (0 for logical, sign-fill for arithmetic).

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, all sh_*=0, illegal_cnt=0; in_ready=1 after release.
- shra imm: in_rs=32'hF000_0000, imm=4, out_ready=1 -> next cycle out_valid=1, sh_in=F0000000, sh_shamt=4, sh_arith=1, sh_left=0.
- Backpressure: 3 back-to-back shllv ops, tags 1,2,3, out_ready=0 -> tags 1,2 held (M,S), in_ready=0 on the 3rd. Release out_ready -> tags emerge 1,2,3 in order, no loss or duplication.
- Variable mask: in_rt=32'h0000_0025 with MASK_VAR_SHAMT=1 -> sh_shamt=5; with MASK_VAR_SHAMT=0 -> sh_shamt=0x25.
- Illegal: func=111 accepted -> no out_valid, err_illegal pulse 1 cycle, illegal_cnt=1. Issue 300 illegal ops with ERR_CNT_W=8 -> illegal_cnt saturates at 255.
- Flush/reset mid-op: M and S full, assert flush (then separately rst) -> out_valid=0 next cycle; the following legal op appears with 1-cycle latency.
